node_traffic_source: RTL and testbench
======================================

Name: node_traffic_source

Overview:
- Per-node packet generator that drives one node-to-network port of the mesh `network`. One instance per node.
- Emits single-word packets: destination drawn from an LFSR, configurable inter-packet gap, optional packet limit.
- Obeys the network's hold (backpressure) signal.
- Used as the stimulus stage in network benches.

Parameters:
- X_NODES, 3, mesh columns
- Y_NODES, 3, mesh rows
- FIFO_WIDTH, 32, word width; must be at least 2*ID_W+2
- NODE_ID, 0, this node's index, 0..X_NODES*Y_NODES-1
- GAP, 4, idle cycles between an accepted word and the next write request; 0 means back-to-back
- NUM_PACKETS, 0, packets to send before stopping; 0 means unlimited
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'hACE1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; permits packet generation
- networkToNodeHoldRequest  in  1  network cannot accept this cycle
- nodeToNetworkData  out  FIFO_WIDTH  packet word
- nodeToNetworkWriteRequest  out  1  word valid
- packetsSent  out  16  count of accepted words, wraps
- done  out  1  NUM_PACKETS reached

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Reset dominates every other input.
- Derived widths:
  - N = X_NODES*Y_NODES
  - ID_W = $clog2(N)
  - SEQ_W = FIFO_WIDTH-1-2*ID_W
- Word format, MSB down:
  - [FIFO_WIDTH-1] = 1 (valid marker)
  - next ID_W bits = destination
  - next ID_W bits = NODE_ID
  - low SEQ_W bits = sequence number
  - Defaults give: bit31 = 1, [30:27] = dest, [26:23] = src, [22:0] = seq.
- Reset values:
  - nodeToNetworkWriteRequest = 0, nodeToNetworkData = 0
  - packetsSent = 0, done = 0, sequence = 0
  - LFSR = seed, state = IDLE
- Acceptance: a word is accepted at a rising edge where nodeToNetworkWriteRequest = 1 and networkToNodeHoldRequest = 0.
- Stall: while the request is high and the word is not accepted, data and request stay bit-stable. A held word is never dropped, duplicated or altered.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances by one step only on acceptance.
  - dest = lfsr mod N; if dest == NODE_ID, use (dest+1) mod N. Self-addressed packets are never emitted.
  - The word loaded into SEND uses the current LFSR value.
- Sequence: increments on acceptance, wraps modulo 2^SEQ_W. packetsSent increments on acceptance, wraps at 16 bits.
- States:
  - IDLE: request = 0.
    - enable = 1 and not done → SEND, loading a new word.
  - SEND: request = 1. On acceptance:
    - if NUM_PACKETS != 0 and the new packetsSent == NUM_PACKETS → DONE
    - else if enable = 0 → IDLE
    - else if GAP == 0 → stay in SEND with the next word (back-to-back, request stays high)
    - else → GAP with cnt = GAP-1
    - Without acceptance, stay in SEND. enable falling mid-stall does not abort the word.
  - GAP: request = 0.
    - enable = 0 → IDLE
    - else if cnt == 0 → SEND, loading a new word
    - else cnt-1
  - DONE: request = 0, done = 1. Exits only on reset.
- Timing:
  - First request rises on the edge after enable is sampled high in IDLE.
  - Exactly GAP request-low cycles separate an acceptance from the next request.
- Hold behaviour: hold asserted while not requesting has no effect.
- Reset in any state, including mid-stall: next edge returns to reset values. The pending word is discarded.

Test Plan:
- Format check: NODE_ID=8, GAP=2, hold=0, enable=1 from cycle 0 after reset.
  - Each word has bit31 = 1, [26:23] = 4'b1000, [30:27] in 0..7, seq = 0,1,2,…
  - Request pattern: high one cycle, then exactly 2 cycles low.
- Back-to-back: GAP=0, hold=0.
  - Request high continuously.
  - New seq every cycle; packetsSent matches the cycle count; LFSR advances every cycle.
- Stall: hold=1 for 3 cycles while the request is high.
  - Data and request are identical across all 3 cycles.
  - Accepted exactly once on hold release; seq has no gap; packetsSent +1 only.
- Limit: NUM_PACKETS=3, GAP=1.
  - Exactly 3 acceptances, then done = 1 and the request is never reasserted.
  - packetsSent stays 3 while enable stays 1.
- Enable drop:
  - Deassert enable mid-GAP → IDLE, no further request.
  - Deassert during a stall → word still completes on hold release, then IDLE.
  - Reassert → request on the next edge with seq continuing.
- Reset mid-stall: reset=1 for 1 cycle with the request high and hold=1.
  - Request = 0, packetsSent = 0, seq restarts at 0.
  - LFSR reseeded: first destination after reset equals the first destination after power-up.

Source files
------------

// File: rtl/node_traffic_source_if.sv
// Node-to-network port bundle: word, valid and network backpressure.
// Signal names match the mesh network's node port.
interface node_traffic_source_if #(
  parameter int FIFO_WIDTH = 32
);
  logic [FIFO_WIDTH-1:0] nodeToNetworkData;
  logic                  nodeToNetworkWriteRequest;
  logic                  networkToNodeHoldRequest;

  modport master (
    output nodeToNetworkData,
    output nodeToNetworkWriteRequest,
    input  networkToNodeHoldRequest
  );

  modport slave (
    input  nodeToNetworkData,
    input  nodeToNetworkWriteRequest,
    output networkToNodeHoldRequest
  );
endinterface

// File: rtl/node_traffic_source.sv
// Per-node packet generator for the mesh network.
// Emits one-word packets to LFSR-chosen destinations with a fixed gap.
module node_traffic_source #(
  parameter int          X_NODES     = 3,
  parameter int          Y_NODES     = 3,
  parameter int          FIFO_WIDTH  = 32,
  parameter int          NODE_ID     = 0,
  parameter int          GAP         = 4,
  parameter int          NUM_PACKETS = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  node_traffic_source_if.master  port,
  output logic [15:0]            packetsSent,
  output logic                   done
);

  localparam int N     = X_NODES * Y_NODES;
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SEQ_W = FIFO_WIDTH - 1 - 2 * ID_W;
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [15:0]           lfsr, lfsr_n;
  logic [15:0]           sent_n;
  logic [15:0]           cnt, cnt_n;
  logic [SEQ_W-1:0]      seq, seq_n;
  logic [FIFO_WIDTH-1:0] data_n;
  logic                  req_n;
  logic                  done_n;
  logic                  accept;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] l
  );
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Self-addressed destinations are bumped to the next node.
  function automatic logic [FIFO_WIDTH-1:0] make_word(
    input logic [15:0]      l,
    input logic [SEQ_W-1:0] s
  );
    int d;
    d = int'(l) % N;
    if (d == NODE_ID) d = (d + 1) % N;
    return {1'b1, ID_W'(d), ID_W'(NODE_ID), s};
  endfunction

  assign accept = port.nodeToNetworkWriteRequest
                & ~port.networkToNodeHoldRequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                          <= S_IDLE;
      lfsr                           <= SEED;
      seq                            <= '0;
      cnt                            <= '0;
      packetsSent                    <= '0;
      done                           <= 1'b0;
      port.nodeToNetworkData         <= '0;
      port.nodeToNetworkWriteRequest <= 1'b0;
    end else begin
      state                          <= state_n;
      lfsr                           <= lfsr_n;
      seq                            <= seq_n;
      cnt                            <= cnt_n;
      packetsSent                    <= sent_n;
      done                           <= done_n;
      port.nodeToNetworkData         <= data_n;
      port.nodeToNetworkWriteRequest <= req_n;
    end
  end

  always_comb begin
    state_n = state;
    lfsr_n  = accept ? lfsr_step(lfsr) : lfsr;
    seq_n   = accept ? seq + 1'b1 : seq;
    sent_n  = accept ? packetsSent + 16'd1 : packetsSent;
    cnt_n   = cnt;
    data_n  = port.nodeToNetworkData;
    req_n   = 1'b0;
    done_n  = done;
    unique case (state)
      S_IDLE: begin
        if (enable && !done) begin
          state_n = S_SEND;
          req_n   = 1'b1;
          data_n  = make_word(lfsr, seq);
        end
      end
      S_SEND: begin
        req_n = 1'b1;
        if (accept) begin
          if (NUM_PACKETS != 0 &&
              sent_n == 16'(NUM_PACKETS)) begin
            state_n = S_DONE;
            req_n   = 1'b0;
            done_n  = 1'b1;
          end else if (!enable) begin
            state_n = S_IDLE;
            req_n   = 1'b0;
          end else if (GAP == 0) begin
            data_n = make_word(lfsr_n, seq_n);
          end else begin
            state_n = S_GAP;
            req_n   = 1'b0;
            cnt_n   = 16'(GAP - 1);
          end
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (cnt == 16'd0) begin
          state_n = S_SEND;
          req_n   = 1'b1;
          data_n  = make_word(lfsr, seq);
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DONE: begin
        done_n = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_node_traffic_source.sv
// Randomised bench for node_traffic_source: three configurations
// checked every cycle against a packet-index reference model.
module tb_node_traffic_source;

  logic        clk;
  logic        rst  [3];
  logic        en   [3];
  logic        hold [3];
  logic [31:0] data [3];
  logic        req  [3];
  logic        dn   [3];
  logic [15:0] sent [3];

  int vectors;
  int errors;

  int gapp [3] = '{2, 0, 1};
  int nump [3] = '{0, 0, 3};
  int node [3] = '{8, 4, 0};

  int          mk   [3];
  bit          pend [3];
  int          gl   [3];
  bit          fin  [3];
  logic [15:0] ml   [3];
  bit          jr   [3];

  node_traffic_source_if #(.FIFO_WIDTH(32)) ifa ();
  node_traffic_source_if #(.FIFO_WIDTH(32)) ifb ();
  node_traffic_source_if #(.FIFO_WIDTH(32)) ifc ();

  assign ifa.networkToNodeHoldRequest = hold[0];
  assign ifb.networkToNodeHoldRequest = hold[1];
  assign ifc.networkToNodeHoldRequest = hold[2];
  assign data[0] = ifa.nodeToNetworkData;
  assign data[1] = ifb.nodeToNetworkData;
  assign data[2] = ifc.nodeToNetworkData;
  assign req[0]  = ifa.nodeToNetworkWriteRequest;
  assign req[1]  = ifb.nodeToNetworkWriteRequest;
  assign req[2]  = ifc.nodeToNetworkWriteRequest;

  node_traffic_source #(
    .NODE_ID(8), .GAP(2), .NUM_PACKETS(0)
  ) u0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]),
    .port(ifa.master), .packetsSent(sent[0]), .done(dn[0])
  );

  node_traffic_source #(
    .NODE_ID(4), .GAP(0), .NUM_PACKETS(0)
  ) u1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]),
    .port(ifb.master), .packetsSent(sent[1]), .done(dn[1])
  );

  node_traffic_source #(
    .NODE_ID(0), .GAP(1), .NUM_PACKETS(3)
  ) u2 (
    .clk(clk), .reset(rst[2]), .enable(en[2]),
    .port(ifc.master), .packetsSent(sent[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] next_lfsr(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Word for the packet with index mk[i] since the last reset.
  function automatic logic [31:0] exp_word(input int i);
    int d;
    d = int'(ml[i]) % 9;
    if (d == node[i]) d = (d + 1) % 9;
    return 32'h8000_0000
         | (32'(d) << 27)
         | (32'(node[i]) << 23)
         | (32'(mk[i]) & 32'h007f_ffff);
  endfunction

  task automatic model_update(input int i);
    if (rst[i]) begin
      mk[i] = 0; pend[i] = 0; gl[i] = 0; fin[i] = 0;
      ml[i] = 16'hACE1; jr[i] = 1;
    end else begin
      jr[i] = 0;
      if (pend[i]) begin
        if (!hold[i]) begin
          mk[i]++;
          ml[i] = next_lfsr(ml[i]);
          if (nump[i] != 0 && mk[i] == nump[i]) begin
            fin[i] = 1; pend[i] = 0;
          end else if (!en[i]) begin
            pend[i] = 0;
          end else if (gapp[i] > 0) begin
            pend[i] = 0; gl[i] = gapp[i];
          end
        end
      end else if (gl[i] > 0) begin
        if (!en[i]) gl[i] = 0;
        else begin
          gl[i]--;
          if (gl[i] == 0) pend[i] = 1;
        end
      end else if (!fin[i] && en[i]) begin
        pend[i] = 1;
      end
    end
  endtask

  task automatic do_checks(input int i);
    check($sformatf("u%0d.req", i), 32'(req[i]), 32'(pend[i]));
    check($sformatf("u%0d.done", i), 32'(dn[i]), 32'(fin[i]));
    check($sformatf("u%0d.sent", i), 32'(sent[i]), 32'(16'(mk[i])));
    if (pend[i])
      check($sformatf("u%0d.data", i), data[i], exp_word(i));
    if (pend[i])
      check($sformatf("u%0d.not_self", i),
            32'(data[i][30:27] != 4'(node[i])), 32'd1);
    if (jr[i])
      check($sformatf("u%0d.rst_data", i), data[i], 32'd0);
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) model_update(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) do_checks(i);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    vectors = 0;
    errors  = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; en[i] = 0; hold[i] = 0;
      mk[i] = 0; pend[i] = 0; gl[i] = 0; fin[i] = 0;
      ml[i] = 16'hACE1; jr[i] = 0;
    end
    repeat (2) step();

    for (int i = 0; i < 3; i++) begin
      rst[i] = 0; en[i] = 1;
    end
    repeat (30) step();
    check("u2.limit_sent", 32'(sent[2]), 32'd3);
    check("u2.limit_done", 32'(dn[2]), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        rst[i]  = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        hold[i] = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    // Reset while u0 is stalled with a pending word.
    for (int i = 0; i < 3; i++) begin
      rst[i] = 0; en[i] = 1; hold[i] = 1;
    end
    waited = 0;
    while (!req[0] && waited < 50) begin
      step();
      waited++;
    end
    check("u0.stall_wait", 32'(req[0]), 32'd1);
    repeat (3) step();
    rst[0] = 1;
    step();
    rst[0] = 0;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
